// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU operation scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int ALU_WIDTH_DEF = 4;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Two-way combinational round-robin arbiter, one-hot grant.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            // Under contention the requester that did not win last time goes.
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end else if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/alu_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_scheduler
//  Description : Shares one external add/sub datapath between two requesters
//                with round-robin grant and a valid/ready response channel.
//                Define ALU_SCHED_OVF_EN to add the registered rsp_ovf output.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_m,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_m,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_m,
    input  logic [WIDTH-1:0] alu_s,
    input  logic             alu_cout,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_cout
`ifdef ALU_SCHED_OVF_EN
    ,
    output logic             rsp_ovf
`endif
);

    sched_state_e     r_state;
    sched_state_e     w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_m;
    logic             r_id;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_rsp_s;
    logic             r_rsp_cout;

    logic [1:0]       w_grant;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;
    logic             w_capture;

    rr_arbiter2 u_arb (
        .i_valid0     (req0_valid),
        .i_valid1     (req1_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Gated by rst_n so no ready leaks out while reset is held.
                w_ready0 = rst_n & w_grant[0];
                w_ready1 = rst_n & w_grant[1];
                if ((w_ready0 && req0_valid) || (w_ready1 && req1_valid)) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_capture   = 1'b1;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_m          <= ALU_ADD;
            r_id         <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_a          <= w_grant[1] ? req1_a : req0_a;
            r_b          <= w_grant[1] ? req1_b : req0_b;
            r_m          <= w_grant[1] ? req1_m : req0_m;
            r_id         <= w_grant[1];
            r_last_grant <= w_grant[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_s    <= '0;
            r_rsp_cout <= 1'b0;
        end else if (w_capture) begin
            r_rsp_s    <= alu_s;
            r_rsp_cout <= alu_cout;
        end
    end

`ifdef ALU_SCHED_OVF_EN
    logic [WIDTH-1:0] w_beff;
    logic             w_ovf;
    logic             r_rsp_ovf;

    // Signed overflow: operands agree in sign after effective inversion, result does not.
    assign w_beff = r_b ^ {WIDTH{r_m == ALU_SUB}};
    assign w_ovf  = (r_a[WIDTH-1] == w_beff[WIDTH-1]) && (alu_s[WIDTH-1] != r_a[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_ovf <= 1'b0;
        end else if (w_capture) begin
            r_rsp_ovf <= w_ovf;
        end
    end

    assign rsp_ovf = r_rsp_ovf;
`endif

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;

    assign alu_a = r_a;
    assign alu_b = r_b;
    assign alu_m = r_m;

    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_id    = r_id;
    assign rsp_s     = r_rsp_s;
    assign rsp_cout  = r_rsp_cout;

endmodule : alu_op_scheduler
`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_op_scheduler
//  Description : Directed self-checking bench for alu_op_scheduler with a
//                behavioural add/sub datapath model attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_op_scheduler;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready, req0_m;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_m;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [WIDTH-1:0] alu_a, alu_b, alu_s;
    logic             alu_m, alu_cout;
    logic             rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [WIDTH-1:0] rsp_s;
`ifdef ALU_SCHED_OVF_EN
    logic             rsp_ovf;
`endif

    int n_tests;
    int n_fail;

    // Reference adder: A + B or A + ~B + 1, modulo 2^WIDTH with carry out.
    logic [WIDTH:0] w_sum;
    assign w_sum    = {1'b0, alu_a} + {1'b0, alu_b ^ {WIDTH{alu_m}}} + {{WIDTH{1'b0}}, alu_m};
    assign alu_s    = w_sum[WIDTH-1:0];
    assign alu_cout = w_sum[WIDTH];

    alu_op_scheduler #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_m     (req0_m),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_m     (req1_m),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_m      (alu_m),
        .alu_s      (alu_s),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_s      (rsp_s),
        .rsp_cout   (rsp_cout)
`ifdef ALU_SCHED_OVF_EN
        ,
        .rsp_ovf    (rsp_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation from requester id with rsp_ready held high.
    task automatic do_op(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic m, input logic [WIDTH-1:0] exp_s, input logic exp_c,
                         input logic exp_ovf);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_m = m; end
        else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_m = m; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((id ? req1_ready : req0_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("op_ready_seen", {31'd0, got}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        chk("op_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("op_exec_alu_a", {28'd0, alu_a}, {28'd0, a});
        chk("op_exec_alu_m", {31'd0, alu_m}, {31'd0, m});
        @(negedge clk);
        chk("op_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("op_rsp_s", {28'd0, rsp_s}, {28'd0, exp_s});
        chk("op_rsp_cout", {31'd0, rsp_cout}, {31'd0, exp_c});
        chk("op_rsp_id", {31'd0, rsp_id}, {31'd0, id});
`ifdef ALU_SCHED_OVF_EN
        chk("op_rsp_ovf", {31'd0, rsp_ovf}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) chk("op_ovf_arg", 32'd0, 32'd1);
`endif
        @(negedge clk);
        chk("op_back_idle", {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic exp_g;
        logic [WIDTH-1:0] exp_s;
        n_tests    = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        rsp_ready  = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd1; req0_m = 1'b0;
        req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0; req1_m = 1'b0;

        // Reset values while rst_n is low
        repeat (2) @(negedge clk);
        chk("rst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_s", {28'd0, rsp_s}, 32'd0);
        chk("rst_alu_a", {28'd0, alu_a}, 32'd0);

        // Accept 3+1, then reset mid-EXEC
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("exec_alu_a", {28'd0, alu_a}, 32'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_alu_a", {28'd0, alu_a}, 32'd0);
        chk("midrst_ready0", {31'd0, req0_ready}, 32'd0);
        chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end

        // Contention from reset: grants 0,1,0,1 with 3-cycle throughput
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 4'd5; req0_b = 4'd3; req0_m = 1'b0;
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd3; req1_m = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_g = k[0];
            exp_s = exp_g ? 4'b0011 : 4'b1000;
            @(negedge clk);
            chk("cont_ready0", {31'd0, req0_ready}, {31'd0, ~exp_g});
            chk("cont_ready1", {31'd0, req1_ready}, {31'd0, exp_g});
            @(negedge clk);
            chk("cont_exec_noready", {30'd0, req1_ready, req0_ready}, 32'd0);
            @(negedge clk);
            chk("cont_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("cont_rsp_id", {31'd0, rsp_id}, {31'd0, exp_g});
            chk("cont_rsp_s", {28'd0, rsp_s}, {28'd0, exp_s});
            chk("cont_rsp_cout", {31'd0, rsp_cout}, {31'd0, exp_g});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Single add
        do_op(1'b0, 4'b0011, 4'b0001, 1'b0, 4'b0100, 1'b0, 1'b0);

        // Backpressure on a subtract underflow, req1 waits throughout
        @(posedge clk); #1;
        rsp_ready  = 1'b0;
        req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0010; req0_m = 1'b1;
        @(negedge clk);
        chk("bp_ready0", {31'd0, req0_ready}, 32'd1);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b0001; req1_m = 1'b0;
        @(negedge clk);
        chk("bp_exec_ready1", {31'd0, req1_ready}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_s", {28'd0, rsp_s}, 32'hf);
            chk("bp_rsp_cout", {31'd0, rsp_cout}, 32'd0);
            chk("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_ready_hold", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", {31'd0, rsp_valid}, 32'd0);
        chk("bp_release_ready1", {31'd0, req1_ready}, 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("carry_rsp_s", {28'd0, rsp_s}, 32'd0);
        chk("carry_rsp_cout", {31'd0, rsp_cout}, 32'd1);
        chk("carry_rsp_id", {31'd0, rsp_id}, 32'd1);
`ifdef ALU_SCHED_OVF_EN
        chk("carry_rsp_ovf", {31'd0, rsp_ovf}, 32'd0);
`endif
        @(posedge clk); #1;

        // Signed overflow case and another subtract through requester 1
        do_op(1'b0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        do_op(1'b1, 4'b0001, 4'b0010, 1'b1, 4'b1111, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_alu_op_scheduler
`default_nettype wire
